// File: rtl/xaui_link_sequencer.sv
// XAUI/MAC reset and link bring-up sequencer for a 10G port.
// Runs in the clk156_25 domain; re-sequences on fault or alignment timeout.
module xaui_link_sequencer #(
    parameter int unsigned XRST_CYCLES    = 16,
    parameter int unsigned ALIGN_TIMEOUT  = 65535,
    parameter int unsigned DEBOUNCE       = 64,
    parameter int unsigned MAC_RST_CYCLES = 7
) (
    input  logic       clk156_25,
    input  logic       reset156_25_n,
    input  logic       dcm_locked,
    input  logic [7:0] xaui_status,
    output logic       xaui_reset,
    output logic       mac_reset,
    output logic       link_up,
    output logic [7:0] retry_count,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        XRST       = 3'd1,
        WAIT_ALIGN = 3'd2,
        MRST       = 3'd3,
        UP         = 3'd4
    } state_t;

    localparam logic [15:0] XRST_LAST = 16'(XRST_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(ALIGN_TIMEOUT - 1);
    localparam logic [15:0] DBC_LAST  = 16'(DEBOUNCE - 1);
    localparam logic [15:0] MRST_LAST = 16'(MAC_RST_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dbc_q, dbc_d;
    logic [7:0]  retry_q, retry_d;
    logic        xaui_reset_q, xaui_reset_d;
    logic        mac_reset_q, mac_reset_d;
    logic        link_up_q, link_up_d;
    logic        status_ok;
    logic        retry_inc;

    assign status_ok = (xaui_status[7:2] == 6'h3F) && (xaui_status[1:0] == 2'b00);

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dcm_locked) state_d = XRST;
            end
            XRST: begin
                if (cnt_q == XRST_LAST) state_d = WAIT_ALIGN;
            end
            WAIT_ALIGN: begin
                // Alignment success takes precedence over a coincident timeout
                if (status_ok && dbc_q == DBC_LAST) begin
                    state_d = MRST;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = XRST;
                    retry_inc = 1'b1;
                end
            end
            MRST: begin
                if (cnt_q == MRST_LAST) state_d = UP;
            end
            UP: begin
                if (!status_ok) begin
                    state_d   = XRST;
                    retry_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!dcm_locked && state_q != IDLE) begin
            state_d   = IDLE;
            retry_inc = 1'b0;
        end

        if (state_d != state_q || state_d == IDLE) cnt_d = 16'd0;
        else                                     cnt_d = cnt_q + 16'd1;

        if (state_q == WAIT_ALIGN && state_d == WAIT_ALIGN && status_ok)
            dbc_d = dbc_q + 16'd1;
        else
            dbc_d = 16'd0;

        if (retry_inc && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        else                               retry_d = retry_q;

        xaui_reset_d = (state_d == IDLE) || (state_d == XRST);
        mac_reset_d  = (state_d != UP);
        link_up_d    = (state_d == UP);
    end

    always_ff @(posedge clk156_25 or negedge reset156_25_n) begin
        if (!reset156_25_n) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            dbc_q        <= 16'd0;
            retry_q      <= 8'd0;
            xaui_reset_q <= 1'b1;
            mac_reset_q  <= 1'b1;
            link_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dbc_q        <= dbc_d;
            retry_q      <= retry_d;
            xaui_reset_q <= xaui_reset_d;
            mac_reset_q  <= mac_reset_d;
            link_up_q    <= link_up_d;
        end
    end

    assign xaui_reset  = xaui_reset_q;
    assign mac_reset   = mac_reset_q;
    assign link_up     = link_up_q;
    assign retry_count = retry_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// Directed bench for xaui_link_sequencer: bring-up timing, faults, timeouts,
// lock loss, retry saturation (short-timeout instance) and async reset.
module tb_xaui_link_sequencer;

    logic       clk;
    logic       rst_n;
    logic       dcm;
    logic [7:0] status;
    logic       xrst, mrst, lup;
    logic [7:0] retry;
    logic [2:0] st;

    logic       s_xrst, s_mrst, s_lup;
    logic [7:0] s_retry;
    logic [2:0] s_st;

    int vec_cnt = 0;
    int err_cnt = 0;

    xaui_link_sequencer u_dut (
        .clk156_25    (clk),
        .reset156_25_n(rst_n),
        .dcm_locked   (dcm),
        .xaui_status  (status),
        .xaui_reset   (xrst),
        .mac_reset    (mrst),
        .link_up      (lup),
        .retry_count  (retry),
        .seq_state    (st)
    );

    xaui_link_sequencer #(.ALIGN_TIMEOUT(8)) u_sat (
        .clk156_25    (clk),
        .reset156_25_n(rst_n),
        .dcm_locked   (1'b1),
        .xaui_status  (8'h00),
        .xaui_reset   (s_xrst),
        .mac_reset    (s_mrst),
        .link_up      (s_lup),
        .retry_count  (s_retry),
        .seq_state    (s_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_st,
                              input logic e_x, input logic e_m,
                              input logic e_l, input logic [7:0] e_r);
        check({tag, ".state"}, 32'(st), 32'(e_st));
        check({tag, ".xrst"},  32'(xrst), 32'(e_x));
        check({tag, ".mrst"},  32'(mrst), 32'(e_m));
        check({tag, ".lup"},   32'(lup), 32'(e_l));
        check({tag, ".retry"}, 32'(retry), 32'(e_r));
    endtask

    initial begin
        rst_n  = 1'b0;
        dcm    = 1'b0;
        status = 8'hFC;
        tick(2);
        check_outs("reset", 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        check("sat_reset", 32'(s_retry), 32'd0);

        rst_n = 1'b1;
        tick(3);
        check_outs("idle_nolock", 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);

        // bring-up: lock rises, xaui_reset falls at +17, link_up at +88
        dcm = 1'b1;
        tick(1);
        check_outs("xrst_entry", 3'd1, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(15);
        check("xrst_t16", 32'(xrst), 32'd1);
        tick(1);
        check_outs("wait_t17", 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(63);
        check("wait_t80", 32'(st), 32'd2);
        tick(1);
        check("mrst_t81", 32'(st), 32'd3);
        tick(6);
        check_outs("mrst_t87", 3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        check_outs("up_t88", 3'd4, 1'b0, 1'b0, 1'b1, 8'd0);

        // one-cycle rx local fault in UP
        status = 8'hFE;
        tick(1);
        status = 8'hFC;
        check_outs("fault", 3'd1, 1'b1, 1'b1, 1'b0, 8'd1);
        tick(86);
        check("recov_t86", 32'(lup), 32'd0);
        tick(1);
        check_outs("recov_up", 3'd4, 1'b0, 1'b0, 1'b1, 8'd1);

        // lock loss in MRST
        status = 8'hFD;
        tick(1);
        status = 8'hFC;
        check("fault2.retry", 32'(retry), 32'd2);
        tick(82);
        check("in_mrst", 32'(st), 32'd3);
        dcm = 1'b0;
        tick(1);
        check_outs("lock_loss", 3'd0, 1'b1, 1'b1, 1'b0, 8'd2);

        // alignment timeout with bit6 toggling every 30 cycles
        dcm = 1'b1;
        tick(17);
        check("wait_again", 32'(st), 32'd2);
        for (int i = 0; i < 65534; i++) begin
            status = ((i / 30) % 2 == 0) ? 8'hBC : 8'hFC;
            tick(1);
        end
        status = 8'hFC;
        check_outs("tmo_last", 3'd2, 1'b0, 1'b1, 1'b0, 8'd2);
        tick(1);
        check_outs("tmo", 3'd1, 1'b1, 1'b1, 1'b0, 8'd3);
        tick(15);
        check("tmo_xrst16", 32'(xrst), 32'd1);
        tick(1);
        check_outs("tmo_wait", 3'd2, 1'b0, 1'b1, 1'b0, 8'd3);

        // async reset mid-WAIT_ALIGN
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_outs("restart", 3'd1, 1'b1, 1'b1, 1'b0, 8'd0);

        // saturation on the short-timeout instance: one retry per 24 cycles
        check("sat_first", 32'(s_st), 32'd1);
        tick(24);
        check("sat_r1", 32'(s_retry), 32'd1);
        tick(24 * 254 - 1);
        check("sat_r254", 32'(s_retry), 32'd254);
        tick(1);
        check("sat_r255", 32'(s_retry), 32'd255);
        tick(24 * 46);
        check("sat_hold", 32'(s_retry), 32'd255);
        check("sat_lup", 32'(s_lup), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
